// File: rtl/rbsp_bit_buffer_pkg.sv
// Shared constants and helpers for the RBSP bit reservoir.
package rbsp_bit_buffer_pkg;

  localparam int unsigned RBSP_BUF_BITS = 64;
  localparam int unsigned RBSP_WIN_BITS = 32;
  localparam int unsigned FWD_LEN_W     = 6;
  localparam int unsigned AVAIL_W       = 7;

  function automatic logic [AVAIL_W-1:0] ceil_to_byte(input logic [AVAIL_W-1:0] n);
    logic [AVAIL_W-1:0] r;
    r = n + AVAIL_W'(7);
    return {r[AVAIL_W-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/rbsp_bit_buffer_if.sv
// Byte-in / bit-window-out bus between NAL reader, reservoir and syntax parsers.
interface rbsp_bit_buffer_if;
  import rbsp_bit_buffer_pkg::*;

  logic                     en;
  logic [7:0]               rbsp_data_in;
  logic                     rbsp_valid_in;
  logic                     rd_req_out;
  logic [FWD_LEN_W-1:0]     forward_len_in;
  logic                     align_in;
  logic                     flush_in;
  logic [RBSP_WIN_BITS-1:0] window_out;
  logic [AVAIL_W-1:0]       bits_avail_out;
  logic                     window_valid;
  logic                     underflow_err;

  modport master (
    output en, rbsp_data_in, rbsp_valid_in, forward_len_in, align_in, flush_in,
    input  rd_req_out, window_out, bits_avail_out, window_valid, underflow_err
  );

  modport slave (
    input  en, rbsp_data_in, rbsp_valid_in, forward_len_in, align_in, flush_in,
    output rd_req_out, window_out, bits_avail_out, window_valid, underflow_err
  );

endinterface

// File: rtl/rbsp_bit_buffer_shifter.sv
// Left barrel shift of the reservoir plus insertion of one byte at a variable bit offset.
module rbsp_bit_shifter #(
  parameter int unsigned BUF_BITS = 64,
  parameter int unsigned SH_W     = 6,
  parameter int unsigned CNT_W    = 7
) (
  input  logic [BUF_BITS-1:0] res_in,
  input  logic [SH_W-1:0]     shift_in,
  input  logic                ins_en_in,
  input  logic [CNT_W-1:0]    ins_pos_in,
  input  logic [7:0]          byte_in,
  output logic [BUF_BITS-1:0] res_c
);

  logic [CNT_W-1:0] ins_msb;

  // ins_pos_in counts bits from the oldest end; the byte lands right after them
  always_comb begin
    ins_msb = CNT_W'(BUF_BITS - 1) - ins_pos_in;
    res_c   = res_in << shift_in;
    if (ins_en_in) begin
      res_c[ins_msb -: 8] = byte_in;
    end
  end

endmodule

// File: rtl/rbsp_bit_buffer.sv
// MSB-first RBSP bit reservoir: pulls bytes from the NAL reader, presents a look-ahead window.
module rbsp_bit_buffer
  import rbsp_bit_buffer_pkg::*;
#(
  parameter int unsigned BUF_BITS = RBSP_BUF_BITS,
  parameter int unsigned WIN_BITS = RBSP_WIN_BITS
) (
  input  logic              clk,
  input  logic              rst,
  rbsp_bit_buffer_if.slave  bus
);

  logic [BUF_BITS-1:0]  res_q, res_d, shifted_c;
  logic [AVAIL_W-1:0]   count_q, count_d, c1;
  logic                 err_q, err_d;
  logic                 valid_q, valid_d;
  logic                 rd_req_c, acc;
  logic                 bad_req, under;
  logic [FWD_LEN_W-1:0] fwd, fwd_eff;

  rbsp_bit_shifter #(
    .BUF_BITS (BUF_BITS),
    .SH_W     (FWD_LEN_W),
    .CNT_W    (AVAIL_W)
  ) u_shifter (
    .res_in     (res_q),
    .shift_in   (fwd_eff),
    .ins_en_in  (acc),
    .ins_pos_in (c1),
    .byte_in    (bus.rbsp_data_in),
    .res_c      (shifted_c)
  );

  // Request, consume-length resolution and next-state computation
  always_comb begin
    rd_req_c = bus.en && !bus.flush_in && (count_q <= AVAIL_W'(BUF_BITS - 8));
    acc      = rd_req_c && bus.rbsp_valid_in;
    bad_req  = 1'b0;
    fwd      = bus.forward_len_in;
    if (bus.align_in) begin
      fwd     = FWD_LEN_W'(count_q[2:0]);
      bad_req = (bus.forward_len_in != '0);
    end else if (bus.forward_len_in > FWD_LEN_W'(WIN_BITS)) begin
      fwd     = FWD_LEN_W'(WIN_BITS);
      bad_req = 1'b1;
    end
    under   = (AVAIL_W'(fwd) > count_q);
    fwd_eff = under ? '0 : fwd;
    c1      = count_q - AVAIL_W'(fwd_eff);

    res_d   = res_q;
    count_d = count_q;
    err_d   = err_q;
    valid_d = valid_q;
    if (bus.en) begin
      if (bus.flush_in) begin
        res_d   = '0;
        count_d = '0;
        err_d   = 1'b0;
        valid_d = 1'b0;
      end else begin
        res_d   = shifted_c;
        count_d = c1 + (acc ? AVAIL_W'(8) : AVAIL_W'(0));
        err_d   = err_q | bad_req | under;
        valid_d = (count_d >= AVAIL_W'(WIN_BITS));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      count_q <= count_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign bus.rd_req_out     = rd_req_c;
  assign bus.window_out     = res_q[BUF_BITS-1 -: WIN_BITS];
  assign bus.bits_avail_out = count_q;
  assign bus.window_valid   = valid_q;
  assign bus.underflow_err  = err_q;

endmodule

// File: tb/tb_rbsp_bit_buffer.sv
// Bench for rbsp_bit_buffer: directed scenarios plus random traffic against a bit-queue model.
module tb_rbsp_bit_buffer;
  import rbsp_bit_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rbsp_bit_buffer_if bus();
  rbsp_bit_buffer dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference: the reservoir is simply an ordered queue of bits, oldest first
  bit   mq[$];
  bit   m_err;
  logic seen_req, exp_req;

  function automatic logic [31:0] m_window();
    logic [31:0] w = '0;
    for (int i = 0; i < 32; i++) if (i < mq.size()) w[31-i] = mq[i];
    return w;
  endfunction

  function automatic void model_step(input logic e, input logic [7:0] d, input logic v,
                                     input int fl, input logic al, input logic fs);
    int n;
    if (!e) return;
    if (fs) begin
      mq.delete();
      m_err = 1'b0;
      return;
    end
    if (al) begin
      n = mq.size() % 8;
      if (fl != 0) m_err = 1'b1;
    end else if (fl > 32) begin
      n = 32;
      m_err = 1'b1;
    end else n = fl;
    if (n > mq.size()) m_err = 1'b1;
    else repeat (n) void'(mq.pop_front());
    if (exp_req && v) for (int i = 7; i >= 0; i--) mq.push_back(d[i]);
  endfunction

  task automatic apply(input logic e, input logic [7:0] d, input logic v,
                       input int fl, input logic al, input logic fs);
    bus.en = e; bus.rbsp_data_in = d; bus.rbsp_valid_in = v;
    bus.forward_len_in = 6'(fl); bus.align_in = al; bus.flush_in = fs;
    #1;
    seen_req = bus.rd_req_out;
    exp_req  = e && !fs && (mq.size() <= 56);
    @(posedge clk);
    model_step(e, d, v, fl, al, fs);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0; bus.rbsp_data_in = 8'h00; bus.rbsp_valid_in = 1'b0;
    bus.forward_len_in = '0; bus.align_in = 1'b0; bus.flush_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mq.delete(); m_err = 1'b0;
    chk_cnt++; if (bus.window_out !== 32'h0) begin err_cnt++; $display("FAIL reset_window got=%h exp=0", bus.window_out); end
    chk_cnt++; if (bus.bits_avail_out !== 7'd0) begin err_cnt++; $display("FAIL reset_avail got=%0d exp=0", bus.bits_avail_out); end
    chk_cnt++; if (bus.window_valid !== 1'b0 || bus.underflow_err !== 1'b0) begin err_cnt++; $display("FAIL reset_flags got=%b%b exp=00", bus.window_valid, bus.underflow_err); end
    chk_cnt++; if (bus.rd_req_out !== 1'b0) begin err_cnt++; $display("FAIL reset_rdreq got=%b exp=0", bus.rd_req_out); end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    logic [7:0] bytes [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
    for (int i = 0; i < 4; i++) begin
      apply(1, bytes[i], 1, 0, 0, 0);
      chk_cnt++; if (seen_req !== 1'b1) begin err_cnt++; $display("FAIL fill_rdreq[%0d] got=%b exp=1", i, seen_req); end
    end
    chk_cnt++; if (bus.window_out !== 32'hA53CFF01) begin err_cnt++; $display("FAIL fill_window got=%h exp=a53cff01", bus.window_out); end
    chk_cnt++; if (bus.bits_avail_out !== 7'd32) begin err_cnt++; $display("FAIL fill_avail got=%0d exp=32", bus.bits_avail_out); end
    chk_cnt++; if (bus.window_valid !== 1'b1) begin err_cnt++; $display("FAIL fill_valid got=%b exp=1", bus.window_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      apply(1, bytes[i], 1, 0, 0, 0);
      chk_cnt++; if (seen_req !== 1'b1) begin err_cnt++; $display("FAIL bp_rdreq[%0d] got=%b exp=1", i, seen_req); end
    end
    chk_cnt++; if (bus.bits_avail_out !== 7'd64) begin err_cnt++; $display("FAIL bp_avail got=%0d exp=64", bus.bits_avail_out); end
    apply(1, 8'h99, 1, 0, 0, 0);
    chk_cnt++; if (seen_req !== 1'b0) begin err_cnt++; $display("FAIL bp_stall_rdreq got=%b exp=0", seen_req); end
    chk_cnt++; if (bus.bits_avail_out !== 7'd64) begin err_cnt++; $display("FAIL bp_stall_avail got=%0d exp=64", bus.bits_avail_out); end
    chk_cnt++; if (bus.window_out !== 32'hA53CFF01) begin err_cnt++; $display("FAIL bp_head got=%h exp=a53cff01", bus.window_out); end
    apply(1, 8'h77, 1, 32, 0, 0);
    chk_cnt++; if (bus.window_out !== 32'h11223344) begin err_cnt++; $display("FAIL bp_tail got=%h exp=11223344", bus.window_out); end
    chk_cnt++; if (bus.bits_avail_out !== 7'd32) begin err_cnt++; $display("FAIL bp_tail_avail got=%0d exp=32", bus.bits_avail_out); end
  endtask

  task automatic test_mixed();
    logic [7:0] bytes [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
    apply(1, 8'h00, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) apply(1, bytes[i], 1, 0, 0, 0);
    apply(1, 8'h80, 1, 5, 0, 0);
    chk_cnt++; if (bus.window_out !== m_window()) begin err_cnt++; $display("FAIL mixed_window got=%h exp=%h", bus.window_out, m_window()); end
    chk_cnt++; if (bus.bits_avail_out !== 7'd35) begin err_cnt++; $display("FAIL mixed_avail got=%0d exp=35", bus.bits_avail_out); end
  endtask

  task automatic test_invalid_skip();
    apply(1, 8'hEE, 0, 0, 0, 0);
    chk_cnt++; if (seen_req !== 1'b1) begin err_cnt++; $display("FAIL skip_rdreq got=%b exp=1", seen_req); end
    chk_cnt++; if (bus.bits_avail_out !== 7'd35) begin err_cnt++; $display("FAIL skip_avail got=%0d exp=35", bus.bits_avail_out); end
    apply(1, 8'h5A, 1, 0, 0, 0);
    chk_cnt++; if (bus.bits_avail_out !== 7'd43) begin err_cnt++; $display("FAIL skip_append_avail got=%0d exp=43", bus.bits_avail_out); end
    apply(1, 8'h00, 0, 32, 0, 0);
    chk_cnt++; if (bus.window_out !== m_window()) begin err_cnt++; $display("FAIL skip_contig got=%h exp=%h", bus.window_out, m_window()); end
  endtask

  task automatic test_align_underflow();
    logic [31:0] w_before;
    apply(1, 8'h00, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) apply(1, 8'($urandom), 1, 0, 0, 0);
    apply(1, 8'h00, 0, 3, 0, 0);
    apply(1, 8'h00, 0, 0, 1, 0);
    chk_cnt++; if (bus.bits_avail_out !== 7'd24) begin err_cnt++; $display("FAIL align_avail got=%0d exp=24", bus.bits_avail_out); end
    chk_cnt++; if (bus.window_out !== m_window()) begin err_cnt++; $display("FAIL align_window got=%h exp=%h", bus.window_out, m_window()); end
    chk_cnt++; if (bus.underflow_err !== 1'b0) begin err_cnt++; $display("FAIL align_err got=%b exp=0", bus.underflow_err); end
    w_before = m_window();
    apply(1, 8'h00, 0, 30, 0, 0);
    chk_cnt++; if (bus.bits_avail_out !== 7'd24 || bus.window_out !== w_before) begin err_cnt++; $display("FAIL under_hold got=%0d/%h exp=24/%h", bus.bits_avail_out, bus.window_out, w_before); end
    chk_cnt++; if (bus.underflow_err !== 1'b1) begin err_cnt++; $display("FAIL under_err got=%b exp=1", bus.underflow_err); end
    apply(1, 8'h00, 0, 0, 0, 0);
    chk_cnt++; if (bus.underflow_err !== 1'b1) begin err_cnt++; $display("FAIL under_sticky got=%b exp=1", bus.underflow_err); end
  endtask

  task automatic test_flush();
    apply(1, 8'h00, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) apply(1, 8'($urandom), 1, 0, 0, 0);
    apply(1, 8'h00, 0, 63, 0, 0);
    chk_cnt++; if (bus.underflow_err !== 1'b1 || bus.bits_avail_out !== 7'd8) begin err_cnt++; $display("FAIL clamp got=%b/%0d exp=1/8", bus.underflow_err, bus.bits_avail_out); end
    for (int i = 0; i < 4; i++) apply(1, 8'($urandom), 1, 0, 0, 0);
    chk_cnt++; if (bus.bits_avail_out !== 7'd40) begin err_cnt++; $display("FAIL flush_pre_avail got=%0d exp=40", bus.bits_avail_out); end
    apply(1, 8'hC3, 1, 8, 1, 1);
    chk_cnt++; if (seen_req !== 1'b0) begin err_cnt++; $display("FAIL flush_rdreq got=%b exp=0", seen_req); end
    chk_cnt++; if (bus.bits_avail_out !== 7'd0 || bus.window_out !== 32'h0 || bus.underflow_err !== 1'b0) begin err_cnt++; $display("FAIL flush_state got=%0d/%h/%b exp=0/0/0", bus.bits_avail_out, bus.window_out, bus.underflow_err); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) apply(1, 8'($urandom), 1, 0, 0, 0);
    apply(1, 8'h00, 0, 3, 0, 0);
    apply(1, 8'h00, 0, 60, 0, 0);
    bus.en = 1'b1; bus.rbsp_valid_in = 1'b1; bus.forward_len_in = 6'd4; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mq.delete(); m_err = 1'b0;
    chk_cnt++; if (bus.bits_avail_out !== 7'd0 || bus.window_out !== 32'h0 || bus.underflow_err !== 1'b0 || bus.window_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_mid got=%0d/%h/%b/%b exp=0/0/0/0", bus.bits_avail_out, bus.window_out, bus.underflow_err, bus.window_valid); end
  endtask

  task automatic test_enable_hold();
    logic [31:0] w_before;
    for (int i = 0; i < 3; i++) apply(1, 8'($urandom), 1, 0, 0, 0);
    w_before = m_window();
    apply(0, 8'h5C, 1, 8, 1, 1);
    chk_cnt++; if (seen_req !== 1'b0) begin err_cnt++; $display("FAIL hold_rdreq got=%b exp=0", seen_req); end
    chk_cnt++; if (bus.bits_avail_out !== 7'd24 || bus.window_out !== w_before) begin err_cnt++; $display("FAIL hold_state got=%0d/%h exp=24/%h", bus.bits_avail_out, bus.window_out, w_before); end
  endtask

  task automatic test_random();
    logic e, v, al, fs;
    int fl, lim;
    for (int it = 0; it < 600; it++) begin
      e  = ($urandom % 8) != 0;
      v  = ($urandom % 4) != 0;
      al = ($urandom % 10) == 0;
      fs = ($urandom % 50) == 0;
      lim = (mq.size() < 32) ? mq.size() : 32;
      fl = (($urandom % 12) == 0) ? int'($urandom % 64) : int'($urandom_range(lim, 0));
      if (al && ($urandom % 2) == 0) fl = 0;
      apply(e, 8'($urandom), v, fl, al, fs);
      chk_cnt++; if (seen_req !== exp_req) begin err_cnt++; $display("FAIL rnd_rdreq[%0d] got=%b exp=%b", it, seen_req, exp_req); end
      chk_cnt++; if (bus.bits_avail_out !== 7'(mq.size())) begin err_cnt++; $display("FAIL rnd_avail[%0d] got=%0d exp=%0d", it, bus.bits_avail_out, mq.size()); end
      chk_cnt++; if (bus.window_out !== m_window()) begin err_cnt++; $display("FAIL rnd_window[%0d] got=%h exp=%h", it, bus.window_out, m_window()); end
      chk_cnt++; if (bus.window_valid !== (mq.size() >= 32) || bus.underflow_err !== m_err) begin err_cnt++; $display("FAIL rnd_flags[%0d] got=%b%b exp=%b%b", it, bus.window_valid, bus.underflow_err, (mq.size() >= 32), m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_backpressure();
    test_mixed();
    test_invalid_skip();
    test_align_underflow();
    test_flush();
    test_reset_mid();
    test_enable_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
